alu_exec_unit: RTL and testbench

Multi-cycle RV32 execute ALU. It is the consumer of the 3-bit ALU_Control code produced by the ALU decoder. It accepts an operation plus two operands over a valid/ready handshake and executes it: ADD, SUB and AND in one cycle, COMPARE in one cycle, and LEFT_SHIFT iteratively at one bit per cycle. Result and flags are held under a valid/ready output handshake until the writeback stage consumes them.

---
 rtl/alu_exec_unit.sv | 145 ++++++++++++++
 tb/tb_alu_exec_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - multi-cycle RV32 execute ALU with valid/ready handshakes
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   request handshake; ALU_Control, src_a, src_b sampled on acceptance
//   ALU_Control [2:0]   000 ADD, 001 SUB, 010 AND, 011 LEFT_SHIFT, 100 COMPARE, 101-111 illegal
//   src_a, src_b        operands; src_b[SHAMT_W-1:0] is the LEFT_SHIFT amount
//   out_valid/out_ready result handshake; result and flags held while out_valid && !out_ready
//   result, zero, lt, illegal  registered result and flags

module alu_exec_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         ALU_Control,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               lt,
  output logic               illegal
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

  localparam logic [2:0] OP_ADD     = 3'b000;
  localparam logic [2:0] OP_SUB     = 3'b001;
  localparam logic [2:0] OP_AND     = 3'b010;
  localparam logic [2:0] OP_LSHIFT  = 3'b011;
  localparam logic [2:0] OP_COMPARE = 3'b100;

  localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

  logic [1:0]         state_q,   state_d;
  logic [WIDTH-1:0]   result_q,  result_d;
  logic               zero_q,    zero_d;
  logic               lt_q,      lt_d;
  logic               illegal_q, illegal_d;
  logic [SHAMT_W-1:0] cnt_q,     cnt_d;

  logic               accept;
  logic               release_out;
  logic [SHAMT_W-1:0] shamt;
  logic               signed_lt;

  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = (state_q == ST_DONE);
  assign accept      = in_valid && in_ready;
  assign release_out = out_valid && out_ready;
  assign shamt       = src_b[SHAMT_W-1:0];
  assign signed_lt   = $signed(src_a) < $signed(src_b);

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    lt_d      = lt_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          // Every acceptance clears the sticky flags; only the op itself may set them.
          lt_d      = 1'b0;
          illegal_d = 1'b0;
          state_d   = ST_DONE;
          case (ALU_Control)
            OP_ADD:     result_d = src_a + src_b;
            OP_SUB:     result_d = src_a - src_b;
            OP_AND:     result_d = src_a & src_b;
            OP_COMPARE: begin
              lt_d     = signed_lt;
              result_d = {{(WIDTH-1){1'b0}}, signed_lt};
            end
            OP_LSHIFT: begin
              result_d = src_a;
              if (shamt != '0) begin
                cnt_d   = shamt;
                state_d = ST_SHIFT;
              end
            end
            default: begin
              result_d  = '0;
              illegal_d = 1'b1;
            end
          endcase
          zero_d = (result_d == '0);
        end
      end

      ST_SHIFT: begin
        // One bit per cycle; the cycle that sees cnt_q == 1 performs the last shift.
        result_d = {result_q[WIDTH-2:0], 1'b0};
        cnt_d    = cnt_q - CNT_ONE;
        zero_d   = (result_d == '0);
        if (cnt_q == CNT_ONE) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        if (release_out) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      zero_q    <= 1'b0;
      lt_q      <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      lt_q      <= lt_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  assign result  = result_q;
  assign zero    = zero_q;
  assign lt      = lt_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - directed self-checking bench for alu_exec_unit

module tb_alu_exec_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  ALU_Control;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        lt;
  logic        illegal;

  int n_tests = 0;
  int n_fail  = 0;

  alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .ALU_Control (ALU_Control),
    .src_a       (src_a),
    .src_b       (src_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .lt          (lt),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Presents a request at a negedge, waits for acceptance, then scrambles the
  // inputs and counts negedges until out_valid (bounded).
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
    int guard;
    @(negedge clk);
    in_valid    = 1'b1;
    ALU_Control = op;
    src_a       = a;
    src_b       = b;
    guard       = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    ALU_Control = 3'b010;
    src_a       = 32'hDEAD_BEEF;
    src_b       = 32'hFFFF_FFFF;
    lat         = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 100);
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic        exp_zero;
    logic        exp_lt;
    logic        exp_ill;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int lat;
    int guard;
    string tag;

    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    ALU_Control = 3'b000;
    src_a       = 32'h0;
    src_b       = 32'h0;

    #12;
    check_eq("rst_in_ready",  32'(in_ready),  32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_result",    result,         32'h0);
    check_eq("rst_zero",      32'(zero),      32'd0);
    check_eq("rst_lt",        32'(lt),        32'd0);
    check_eq("rst_illegal",   32'(illegal),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    vecs.push_back('{"add_wrap",   3'b000, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1'b0, 1'b0, 1});
    vecs.push_back('{"sub_wrap",   3'b001, 32'h0,         32'h1,         32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{"cmp_neg",    3'b100, 32'hFFFF_FFFE, 32'h1,         32'h1,         1'b0, 1'b1, 1'b0, 1});
    vecs.push_back('{"cmp_eq",     3'b100, 32'h5,         32'h5,         32'h0,         1'b1, 1'b0, 1'b0, 1});
    vecs.push_back('{"cmp_pos_gt", 3'b100, 32'h1,         32'h8000_0000, 32'h0,         1'b1, 1'b0, 1'b0, 1});
    vecs.push_back('{"shl_31",     3'b011, 32'h1,         32'h1F,        32'h8000_0000, 1'b0, 1'b0, 1'b0, 32});
    vecs.push_back('{"shl_0",      3'b011, 32'h1,         32'h20,        32'h1,         1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{"shl_hi_ign", 3'b011, 32'h8000_0001, 32'hFFFF_FFE1, 32'h2,         1'b0, 1'b0, 1'b0, 2});
    vecs.push_back('{"shl_to_0",   3'b011, 32'h8000_0000, 32'h4,         32'h0,         1'b1, 1'b0, 1'b0, 5});
    vecs.push_back('{"illegal",    3'b111, 32'h1234,      32'h1,         32'h0,         1'b1, 1'b0, 1'b1, 1});
    vecs.push_back('{"add_clr",    3'b000, 32'h2,         32'h3,         32'h5,         1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{"illegal101", 3'b101, 32'hFFFF,      32'hFFFF,      32'h0,         1'b1, 1'b0, 1'b1, 1});
    vecs.push_back('{"cmp_clr",    3'b100, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1,         1'b0, 1'b1, 1'b0, 1});

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      tag = vecs[i].name;
      check_eq({tag, "_lat"},     32'(lat),       32'(vecs[i].exp_lat));
      check_eq({tag, "_result"},  result,         vecs[i].exp_res);
      check_eq({tag, "_zero"},    32'(zero),      32'(vecs[i].exp_zero));
      check_eq({tag, "_lt"},      32'(lt),        32'(vecs[i].exp_lt));
      check_eq({tag, "_illegal"}, 32'(illegal),   32'(vecs[i].exp_ill));
      check_eq({tag, "_inrdy"},   32'(in_ready),  32'd0);
      consume();
      check_eq({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
      check_eq({tag, "_hold"},    result,         vecs[i].exp_res);
    end

    // Back-pressure: result held, new request parked until the output handshake.
    run_op(3'b010, 32'hF0F0_F0F0, 32'hFF00_FF00, lat);
    check_eq("bp_lat", 32'(lat), 32'd1);
    @(negedge clk);
    in_valid    = 1'b1;
    ALU_Control = 3'b000;
    src_a       = 32'h10;
    src_b       = 32'h20;
    for (int k = 0; k < 4; k++) begin
      check_eq("bp_result",    result,         32'hF000_F000);
      check_eq("bp_out_valid", 32'(out_valid), 32'd1);
      check_eq("bp_in_ready",  32'(in_ready),  32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq("bp_idle_rdy", 32'(in_ready),  32'd1);
    check_eq("bp_idle_ov",  32'(out_valid), 32'd0);
    check_eq("bp_idle_res", result,         32'hF000_F000);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_eq("bp_next_ov",  32'(out_valid), 32'd1);
    check_eq("bp_next_res", result,         32'h30);
    consume();

    // Asynchronous reset in the middle of a 20-bit shift.
    run_op(3'b011, 32'h1, 32'd20, lat);
    check_eq("mid_shl_lat", 32'(lat), 32'd21);
    consume();
    @(negedge clk);
    in_valid    = 1'b1;
    ALU_Control = 3'b011;
    src_a       = 32'h1;
    src_b       = 32'd20;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("mid_busy", 32'(in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_ov",  32'(out_valid), 32'd0);
    check_eq("mid_rst_rdy", 32'(in_ready),  32'd1);
    check_eq("mid_rst_res", result,         32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    guard = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (out_valid) guard++;
    end
    check_eq("mid_no_stale", 32'(guard), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
